// File: rtl/synth_pkg.sv
// Shared types for the polyphony scheduler: voice/allocator states and the captured note event.
package synth_pkg;

  localparam int NOTE_BITS = 8;
  localparam int VEL_BITS  = 8;

  typedef enum logic [1:0] {V_IDLE, V_ACTIVE, V_RELEASE} voice_state_e;
  typedef enum logic [1:0] {A_IDLE, A_SCAN, A_APPLY} alloc_state_e;

  typedef struct packed {
    logic                 on;
    logic [NOTE_BITS-1:0] note;
    logic [VEL_BITS-1:0]  velocity;
  } note_event_t;

endpackage

// File: rtl/voice_slot.sv
// One voice: state, volume, pitch, age and release-tail timer, driven by allocator strobes.
module voice_slot
  import synth_pkg::*;
#(
  parameter int VOLUME_BITS    = 8,
  parameter int FREQ_RES_BITS  = 8,
  parameter int RELEASE_CYCLES = 65536,
  parameter int AGE_BITS       = 4
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     alloc_i,
  input  logic [VOLUME_BITS-1:0]   vol_i,
  input  logic [FREQ_RES_BITS-1:0] freq_i,
  input  logic                     release_i,
  input  logic                     age_inc_i,
  output voice_state_e             state_o,
  output logic [VOLUME_BITS-1:0]   volume_o,
  output logic [FREQ_RES_BITS-1:0] freq_o,
  output logic [AGE_BITS-1:0]      age_o
);

  localparam int TIMER_BITS = $clog2(RELEASE_CYCLES + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_INIT = TIMER_BITS'(RELEASE_CYCLES);
  localparam logic [AGE_BITS-1:0]   AGE_MAX    = '1;

  voice_state_e             state_q;
  logic [VOLUME_BITS-1:0]   volume_q;
  logic [FREQ_RES_BITS-1:0] freq_q;
  logic [AGE_BITS-1:0]      age_q;
  logic [TIMER_BITS-1:0]    timer_q;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q  <= V_IDLE;
      volume_q <= '0;
      freq_q   <= '0;
      age_q    <= '0;
      timer_q  <= '0;
    end else begin
      if (timer_q != '0) timer_q <= timer_q - 1'b1;
      // Allocation outranks release and timer expiry landing on the same edge.
      if (alloc_i) begin
        state_q  <= V_ACTIVE;
        volume_q <= vol_i;
        freq_q   <= freq_i;
        age_q    <= '0;
        timer_q  <= '0;
      end else begin
        if (release_i && state_q == V_ACTIVE) begin
          state_q  <= V_RELEASE;
          volume_q <= '0;
          timer_q  <= TIMER_INIT;
        end else if (state_q == V_RELEASE && timer_q == TIMER_BITS'(1)) begin
          state_q <= V_IDLE;
        end
        if (age_inc_i && state_q != V_IDLE && age_q != AGE_MAX) age_q <= age_q + 1'b1;
      end
    end
  end

  assign state_o  = state_q;
  assign volume_o = volume_q;
  assign freq_o   = freq_q;
  assign age_o    = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: accepts note events, scans voices one per cycle, then applies one allocation.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES     = 8,
  parameter int VOLUME_BITS    = VEL_BITS,
  parameter int FREQ_RES_BITS  = NOTE_BITS,
  parameter int RELEASE_CYCLES = 65536,
  parameter int AGE_BITS       = 4
) (
  input  logic                                mclk,
  input  logic                                rst,
  input  logic                                ev_valid,
  output logic                                ev_ready,
  input  logic                                ev_on,
  input  logic [FREQ_RES_BITS-1:0]            ev_note,
  input  logic [VOLUME_BITS-1:0]              ev_velocity,
  input  logic                                all_notes_off,
  output logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_volume,
  output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]               voice_busy,
  output logic                                steal_pulse
);

  localparam int IDX_BITS = $clog2(NUM_VOICES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);

  voice_state_e             slot_state [NUM_VOICES];
  logic [VOLUME_BITS-1:0]   slot_vol   [NUM_VOICES];
  logic [FREQ_RES_BITS-1:0] slot_freq  [NUM_VOICES];
  logic [AGE_BITS-1:0]      slot_age   [NUM_VOICES];
  logic [NUM_VOICES-1:0]    alloc_vec, release_vec, age_inc_vec;

  alloc_state_e         fsm_q;
  logic                 ready_q, steal_q;
  note_event_t          ev_q;
  logic [IDX_BITS-1:0]  scan_idx_q;
  logic                 match_found_q, idle_found_q, rel_found_q, act_found_q;
  logic [IDX_BITS-1:0]  match_idx_q, idle_idx_q, rel_idx_q, act_idx_q;
  logic [AGE_BITS-1:0]  rel_age_q, act_age_q;

  logic                 accept, is_note_on, do_apply, steal_d;
  logic [IDX_BITS-1:0]  target_d;
  voice_state_e         cur_state;
  logic [FREQ_RES_BITS-1:0] cur_freq;
  logic [AGE_BITS-1:0]  cur_age;

  assign ev_ready   = ready_q & ~all_notes_off;
  assign accept     = ev_valid & ev_ready;
  assign is_note_on = ev_q.on && ev_q.velocity != '0;
  assign do_apply   = fsm_q == A_APPLY && !all_notes_off;
  assign cur_state  = slot_state[scan_idx_q];
  assign cur_freq   = slot_freq[scan_idx_q];
  assign cur_age    = slot_age[scan_idx_q];

  // Later assignments override earlier ones, so the last match below has highest priority.
  always_comb begin
    target_d = act_idx_q;
    steal_d  = is_note_on && act_found_q;
    if (rel_found_q)   begin target_d = rel_idx_q;   steal_d = 1'b0; end
    if (idle_found_q)  begin target_d = idle_idx_q;  steal_d = 1'b0; end
    if (match_found_q) begin target_d = match_idx_q; steal_d = 1'b0; end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      fsm_q         <= A_IDLE;
      ready_q       <= 1'b0;
      steal_q       <= 1'b0;
      ev_q          <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      idle_found_q  <= 1'b0;
      rel_found_q   <= 1'b0;
      act_found_q   <= 1'b0;
      match_idx_q   <= '0;
      idle_idx_q    <= '0;
      rel_idx_q     <= '0;
      act_idx_q     <= '0;
      rel_age_q     <= '0;
      act_age_q     <= '0;
    end else begin
      steal_q <= 1'b0;
      if (all_notes_off) begin
        fsm_q   <= A_IDLE;
        ready_q <= 1'b0;
      end else begin
        case (fsm_q)
          A_IDLE: begin
            if (accept) begin
              ev_q          <= '{on: ev_on, note: ev_note, velocity: ev_velocity};
              fsm_q         <= A_SCAN;
              ready_q       <= 1'b0;
              scan_idx_q    <= '0;
              match_found_q <= 1'b0;
              idle_found_q  <= 1'b0;
              rel_found_q   <= 1'b0;
              act_found_q   <= 1'b0;
            end else begin
              ready_q <= 1'b1;
            end
          end
          A_SCAN: begin
            // Strict comparisons keep the lowest index on ties.
            if (cur_state != V_IDLE && cur_freq == ev_q.note && !match_found_q) begin
              match_found_q <= 1'b1;
              match_idx_q   <= scan_idx_q;
            end
            if (cur_state == V_IDLE && !idle_found_q) begin
              idle_found_q <= 1'b1;
              idle_idx_q   <= scan_idx_q;
            end
            if (cur_state == V_RELEASE && (!rel_found_q || cur_age > rel_age_q)) begin
              rel_found_q <= 1'b1;
              rel_idx_q   <= scan_idx_q;
              rel_age_q   <= cur_age;
            end
            if (cur_state == V_ACTIVE && (!act_found_q || cur_age > act_age_q)) begin
              act_found_q <= 1'b1;
              act_idx_q   <= scan_idx_q;
              act_age_q   <= cur_age;
            end
            if (scan_idx_q == LAST_IDX) fsm_q <= A_APPLY;
            else                        scan_idx_q <= scan_idx_q + 1'b1;
          end
          A_APPLY: begin
            fsm_q   <= A_IDLE;
            steal_q <= steal_d;
          end
          default: fsm_q <= A_IDLE;
        endcase
      end
    end
  end

  assign steal_pulse = steal_q;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign alloc_vec[gi]   = do_apply && is_note_on && target_d == IDX_BITS'(gi);
    assign age_inc_vec[gi] = do_apply && is_note_on && target_d != IDX_BITS'(gi);
    assign release_vec[gi] = all_notes_off ||
                             (do_apply && !is_note_on && slot_freq[gi] == ev_q.note);

    voice_slot #(
      .VOLUME_BITS   (VOLUME_BITS),
      .FREQ_RES_BITS (FREQ_RES_BITS),
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .AGE_BITS      (AGE_BITS)
    ) u_slot (
      .mclk     (mclk),
      .rst      (rst),
      .alloc_i  (alloc_vec[gi]),
      .vol_i    (ev_q.velocity),
      .freq_i   (ev_q.note),
      .release_i(release_vec[gi]),
      .age_inc_i(age_inc_vec[gi]),
      .state_o  (slot_state[gi]),
      .volume_o (slot_vol[gi]),
      .freq_o   (slot_freq[gi]),
      .age_o    (slot_age[gi])
    );

    assign voice_volume[gi*VOLUME_BITS +: VOLUME_BITS]     = slot_vol[gi];
    assign voice_freq[gi*FREQ_RES_BITS +: FREQ_RES_BITS]   = slot_freq[gi];
    assign voice_busy[gi]                                  = slot_state[gi] != V_IDLE;
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with 4 voices and a 100-cycle release tail.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          mclk = 1'b0;
  logic          rst = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_on = 1'b0;
  logic [7:0]    ev_note = '0;
  logic [7:0]    ev_velocity = '0;
  logic          all_notes_off = 1'b0;
  logic [31:0]   voice_volume;
  logic [31:0]   voice_freq;
  logic [NV-1:0] voice_busy;
  logic          steal_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_low_cnt, steal_cnt, busy_cnt;
  logic [7:0] v0_trace [6];

  voice_allocator #(
    .NUM_VOICES(NV), .VOLUME_BITS(8), .FREQ_RES_BITS(8), .RELEASE_CYCLES(100), .AGE_BITS(4)
  ) dut (
    .mclk(mclk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_velocity(ev_velocity), .all_notes_off(all_notes_off),
    .voice_volume(voice_volume), .voice_freq(voice_freq), .voice_busy(voice_busy),
    .steal_pulse(steal_pulse)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for ready, presents one event, and samples ready/steal/voice0 volume over the
  // six cycles that follow the accepting edge; returns on the negedge after ready comes back.
  task automatic send(input logic on, input logic [7:0] note, input logic [7:0] vel);
    int guard = 0;
    @(negedge mclk);
    while (ev_ready !== 1'b1 && guard < 50) begin
      @(negedge mclk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 64'(ev_ready), 64'd1);
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_velocity = vel;
    @(posedge mclk);
    #1 ev_valid = 1'b0;
    rdy_low_cnt = 0;
    steal_cnt   = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge mclk);
      if (ev_ready === 1'b0) rdy_low_cnt++;
      if (steal_pulse === 1'b1) steal_cnt++;
      v0_trace[k] = voice_volume[7:0];
    end
    @(negedge mclk);
    $display("event on=%0d note=%0d vel=%0d -> vol=%08h freq=%08h busy=%b steal_cycles=%0d",
             on, note, vel, voice_volume, voice_freq, voice_busy, steal_cnt);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    @(negedge mclk);
    check("rst_ready", 64'(ev_ready), 64'd0);
    check("rst_volume", 64'(voice_volume), 64'd0);
    check("rst_freq", 64'(voice_freq), 64'd0);
    check("rst_busy", 64'(voice_busy), 64'd0);
    check("rst_steal", 64'(steal_pulse), 64'd0);
    @(negedge mclk);
    rst = 1'b0;
    #1 check("ready_low_before_edge", 64'(ev_ready), 64'd0);
    @(negedge mclk);
    check("ready_after_release", 64'(ev_ready), 64'd1);

    // First note and its latency
    send(1'b1, 8'd60, 8'd100);
    check("t1_vol_before_apply", 64'(v0_trace[4]), 64'd0);
    check("t1_vol_at_apply", 64'(v0_trace[5]), 64'd100);
    check("t1_ready_low_cycles", 64'(rdy_low_cnt), 64'd6);
    check("t1_steal", 64'(steal_cnt), 64'd0);
    check("t1_freq", 64'(voice_freq), 64'h0000_003C);
    check("t1_busy", 64'(voice_busy), 64'b0001);

    // Fill the pool, then steal the oldest
    send(1'b1, 8'd62, 8'd62);
    send(1'b1, 8'd64, 8'd64);
    send(1'b1, 8'd67, 8'd67);
    check("t2_fill_freq", 64'(voice_freq), 64'h4340_3E3C);
    check("t2_fill_steal", 64'(steal_cnt), 64'd0);
    send(1'b1, 8'd69, 8'd69);
    check("t2_steal_freq", 64'(voice_freq), 64'h4340_3E45);
    check("t2_steal_vol", 64'(voice_volume), 64'h4340_3E45);
    check("t2_steal_pulse_cycles", 64'(steal_cnt), 64'd1);
    check("t2_steal_pulse_now", 64'(steal_pulse), 64'd0);

    // Release tail voice is reused before any active voice
    send(1'b0, 8'd62, 8'd0);
    check("t4_off_vol", 64'(voice_volume), 64'h4340_0045);
    check("t4_off_freq", 64'(voice_freq), 64'h4340_3E45);
    check("t4_off_busy", 64'(voice_busy), 64'b1111);
    send(1'b1, 8'd70, 8'd70);
    check("t4_reuse_freq", 64'(voice_freq), 64'h4340_4645);
    check("t4_reuse_vol", 64'(voice_volume), 64'h4340_4645);
    check("t4_reuse_steal", 64'(steal_cnt), 64'd0);
    send(1'b0, 8'd61, 8'd0);
    check("t4_off_nomatch_vol", 64'(voice_volume), 64'h4340_4645);
    check("t4_off_nomatch_ready", 64'(rdy_low_cnt), 64'd6);

    // Note-off and the release-tail length
    do_reset();
    send(1'b1, 8'd60, 8'd100);
    send(1'b0, 8'd60, 8'd0);
    check("t3_off_vol", 64'(voice_volume), 64'd0);
    check("t3_off_freq", 64'(voice_freq), 64'h0000_003C);
    check("t3_off_busy", 64'(voice_busy), 64'b0001);
    busy_cnt = 2;
    for (int k = 0; k < 200; k++) begin
      @(negedge mclk);
      if (voice_busy[0] !== 1'b1) break;
      busy_cnt++;
    end
    check("t3_busy_cycles", 64'(busy_cnt), 64'd100);
    check("t3_idle_freq_held", 64'(voice_freq), 64'h0000_003C);

    // Zero velocity acts as note-off; repeated note reuses its voice
    do_reset();
    send(1'b1, 8'd60, 8'd100);
    send(1'b1, 8'd60, 8'd0);
    check("t5_vel0_vol", 64'(voice_volume), 64'd0);
    check("t5_vel0_busy", 64'(voice_busy), 64'b0001);
    send(1'b1, 8'd60, 8'd50);
    send(1'b1, 8'd60, 8'd50);
    check("t5_same_note_vol", 64'(voice_volume), 64'h0000_0032);
    check("t5_same_note_busy", 64'(voice_busy), 64'b0001);
    check("t5_same_note_freq", 64'(voice_freq), 64'h0000_003C);

    // Panic mid-scan drops the in-flight event
    @(negedge mclk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 8'd62; ev_velocity = 8'd77;
    @(posedge mclk);
    #1 ev_valid = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    all_notes_off = 1'b1;
    #1 check("t6_ready_during_panic", 64'(ev_ready), 64'd0);
    @(negedge mclk);
    check("t6_panic_vol", 64'(voice_volume), 64'd0);
    check("t6_panic_busy", 64'(voice_busy), 64'b0001);
    all_notes_off = 1'b0;
    repeat (8) @(negedge mclk);
    $display("panic -> vol=%08h freq=%08h busy=%b", voice_volume, voice_freq, voice_busy);
    check("t6_dropped_freq", 64'(voice_freq), 64'h0000_003C);
    check("t6_dropped_busy", 64'(voice_busy), 64'b0001);
    check("t6_ready_back", 64'(ev_ready), 64'd1);

    // Reset mid-scan discards the captured event
    @(negedge mclk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 8'd64; ev_velocity = 8'd88;
    @(posedge mclk);
    #1 ev_valid = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    rst = 1'b1;
    #1;
    check("t7_rst_vol", 64'(voice_volume), 64'd0);
    check("t7_rst_freq", 64'(voice_freq), 64'd0);
    check("t7_rst_busy", 64'(voice_busy), 64'd0);
    check("t7_rst_ready", 64'(ev_ready), 64'd0);
    @(negedge mclk);
    rst = 1'b0;
    repeat (8) @(negedge mclk);
    $display("reset mid-scan -> vol=%08h freq=%08h busy=%b", voice_volume, voice_freq, voice_busy);
    check("t7_after_freq", 64'(voice_freq), 64'd0);
    check("t7_after_busy", 64'(voice_busy), 64'd0);
    check("t7_after_ready", 64'(ev_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
